hack_ctrl: RTL and testbench
============================

HACK_CTRL -- requirements
Module: hack_ctrl

Interface
REQ-001 SHALL have one clock and asynchronous active-low reset; ports in order: clk in 1 (rising-edge clock); rst_n in 1 (async active-low reset).
REQ-002 SHALL provide these instruction-fetch ports: instr_req out 1; instr_addr out 15; instr_ack in 1; instr_data in 16.
REQ-003 SHALL provide these data-memory ports: mem_req out 1; mem_we out 1; mem_addr out 15; mem_wdata out 16; mem_rdata in 16; mem_ack in 1.
REQ-004 SHALL provide these ALU-drive ports: alu_x out 16; alu_y out 16; alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no out 1 each; alu_out in 16; alu_zr in 1; alu_ng in 1.
REQ-005 SHALL provide these status ports: pc out 15 (current instruction address); halted out 1 (halt flag, see Configuration).

Function
REQ-006 SHALL hold internal registers A[15:0], D[15:0], PC[14:0], IR[15:0], M[15:0], R[15:0] (result), ZR, NG.
REQ-007 SHALL use these FSM states: FETCH, DECODE, MREAD, EXEC, MWRITE, COMMIT, and HALT (macro only).
REQ-008 In FETCH, SHALL assert instr_req with instr_addr=PC; on instr_ack SHALL latch IR=instr_data, drop instr_req and go to DECODE.
REQ-009 In DECODE with IR[15]=0 (A-instr), SHALL set A={1'b0,IR[14:0]}, PC=PC+1 and go to FETCH; this takes 2 cycles plus ack wait.
REQ-010 In DECODE with IR[15]=1 (C-instr), SHALL go to MREAD if IR[12]=1, else to EXEC.
REQ-011 In MREAD, SHALL assert mem_req with mem_we=0 and mem_addr=A[14:0]; on mem_ack SHALL latch M=mem_rdata and go to EXEC.
REQ-012 In EXEC, SHALL drive alu_x=D, alu_y=(IR[12]?M:A) and {zx,nx,zy,ny,f,no}=IR[11:6]; SHALL latch R=alu_out, ZR=alu_zr, NG=alu_ng in the same cycle; SHALL go to MWRITE if IR[3]=1, else to COMMIT.
REQ-013 Outside EXEC, SHALL drive all six ALU control outputs at 0; alu_x and alu_y SHALL continue to follow REQ-012 muxing.
REQ-014 In MWRITE, SHALL assert mem_req with mem_we=1, mem_addr=A[14:0] (pre-update A) and mem_wdata=R; on mem_ack SHALL go to COMMIT.
REQ-015 In COMMIT, SHALL set A=R if IR[5], and D=R if IR[4], and then return to FETCH.
REQ-016 In COMMIT, the jump condition is jmp=(IR[2]&NG)|(IR[1]&ZR)|(IR[0]&~ZR&~NG); SHALL set PC=A[14:0] (pre-update A) if jmp, else PC+1.
REQ-017 PC SHALL wrap from 0x7FFF to 0x0000 with no error.
REQ-018 req outputs SHALL stay asserted, with address/data stable, until the matching ack; an ack received while the matching req is low SHALL be ignored.
REQ-019 instr_req and mem_req SHALL never be asserted in the same cycle.
REQ-020 pc SHALL equal the PC register at all times.

Reset
REQ-021 When rst_n is low, SHALL immediately set state=FETCH, PC=A=D=IR=M=R=0, ZR=NG=0, instr_req=mem_req=mem_we=0, halted=0.
REQ-022 Reset asserted mid-handshake SHALL drop req immediately, and SHALL discard the pending transaction with no register update.
REQ-023 On the first clock after rst_n rises, SHALL begin FETCH at address 0.

Configuration
REQ-024 Macro HACK_CTRL_HALT_DETECT_EN enables halt detection. When defined: if COMMIT executes IR[2:0]=3'b111, A[14:0]==PC-1 (mod 2^15), and the previously committed instruction was an A-instr, SHALL enter HALT.
REQ-025 In HALT, SHALL set halted=1 and issue no further requests until reset.
REQ-026 When HACK_CTRL_HALT_DETECT_EN is undefined, the halted port SHALL remain present and tied to 0, no HALT state SHALL exist, and such loops SHALL run forever.

Verification
REQ-027 Reset then program @5 (0x0005), D=A (0xEC10) with zero-wait acks -> A=5 after 2nd fetch, D=5, pc=2; alu controls during EXEC = 110000.
REQ-028 A=100, mem[100]=7, instr M=M+1 (0xFDC8) -> one read addr 100, one write addr 100 data 8; PC+1.
REQ-029 D=0xFFFF (-1), A=20, instr D;JLT (0xE304) -> PC=20; with D=0, same instr -> PC+1.
REQ-030 mem_ack delayed 5 cycles during MREAD -> mem_req and mem_addr held stable for 5 cycles; no state advance.
REQ-031 rst_n pulsed low while instr_req is high -> instr_req low within the reset cycle; next fetch at address 0; A and D = 0.
REQ-032 With macro defined, program @7 at address 7, 0;JMP (0xEA87) at address 8 -> halted=1 after COMMIT, no req afterward; with macro undefined, PC alternates 7/8 indefinitely.

Source files
------------

// File: rtl/hack_ctrl.sv
// hack_ctrl: multi-cycle controller for a Hack-style CPU. It fetches
// instructions over a req/ack port, drives an external ALU, and reads and
// writes data memory over a second req/ack port.
//
// Handshake semantics (both ports): a req is asserted with its address and
// data stable and held until the cycle in which the matching ack is sampled
// high on a rising clock edge. That edge completes the transfer. An ack that
// arrives while its req is low is ignored. instr_req and mem_req are never
// high together.
//
// Optional feature: define HACK_CTRL_HALT_DETECT_EN to detect the
// "@here-1; 0;JMP" idle loop and park in a HALT state (halted=1).
// Without the macro, halted is tied low and such loops simply run.
//
// state_q is a plain enum register, so checkers can bind to it directly.
module hack_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_ack,
  input  logic [15:0] instr_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MREAD,
    S_EXEC,
    S_MWRITE,
    S_COMMIT
`ifdef HACK_CTRL_HALT_DETECT_EN
    , S_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, d_q, ir_q, m_q, r_q;
  logic [14:0] pc_q;
  logic        zr_q, ng_q;
  logic [14:0] pc_inc;
  logic        jmp;
  logic        halt_hit;

  assign pc_inc = pc_q + 15'd1;

  // The jump test uses the flags captured in EXEC for this same instruction.
  assign jmp = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~zr_q & ~ng_q);

`ifdef HACK_CTRL_HALT_DETECT_EN
  // Set by an A-instruction, cleared by every C-instruction commit. It marks
  // that the instruction committed just before this one was an A-instruction.
  logic prev_a_q;

  // Idle-loop detector: an unconditional jump back onto the A-instruction
  // that loaded its own target.
  assign halt_hit = (ir_q[2:0] == 3'b111) && (a_q[14:0] == (pc_q - 15'd1)) && prev_a_q;

  // Track whether the last committed instruction was an A-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a_q <= 1'b0;
    end else if (state_q == S_DECODE && !ir_q[15]) begin
      prev_a_q <= 1'b1;
    end else if (state_q == S_COMMIT) begin
      prev_a_q <= 1'b0;
    end
  end

  assign halted = (state_q == S_HALT);
`else
  assign halt_hit = 1'b0;
  assign halted   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (!ir_q[15])     state_d = S_FETCH;
        else if (ir_q[12]) state_d = S_MREAD;
        else               state_d = S_EXEC;
      end
      S_MREAD:  if (mem_ack) state_d = S_EXEC;
      S_EXEC:   state_d = ir_q[3] ? S_MWRITE : S_COMMIT;
      S_MWRITE: if (mem_ack) state_d = S_COMMIT;
      S_COMMIT: begin
`ifdef HACK_CTRL_HALT_DETECT_EN
        state_d = halt_hit ? S_HALT : S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef HACK_CTRL_HALT_DETECT_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  // Datapath registers. Each update happens only in the state that owns it,
  // so a reset in the middle of a handshake leaves nothing half-committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= '0;
      ir_q <= '0;
      m_q  <= '0;
      r_q  <= '0;
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  if (instr_ack) ir_q <= instr_data;
        S_DECODE: begin
          if (!ir_q[15]) begin
            a_q  <= {1'b0, ir_q[14:0]};
            pc_q <= pc_inc;
          end
        end
        S_MREAD:  if (mem_ack) m_q <= mem_rdata;
        S_EXEC: begin
          r_q  <= alu_out;
          zr_q <= alu_zr;
          ng_q <= alu_ng;
        end
        S_COMMIT: begin
          if (ir_q[5]) a_q <= r_q;
          if (ir_q[4]) d_q <= r_q;
          // The jump target is the A value from before this commit.
          pc_q <= jmp ? a_q[14:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs. Requests are qualified with rst_n so they drop the instant
  // reset asserts, even though the state register is already FETCH.
  always_comb begin
    instr_req  = rst_n && (state_q == S_FETCH);
    mem_req    = rst_n && ((state_q == S_MREAD) || (state_q == S_MWRITE));
    mem_we     = rst_n && (state_q == S_MWRITE);
    instr_addr = pc_q;
    mem_addr   = a_q[14:0];
    mem_wdata  = r_q;
  end

  // ALU operands always follow the operand mux; the function bits are live
  // only in EXEC.
  always_comb begin
    alu_x  = d_q;
    alu_y  = ir_q[12] ? m_q : a_q;
    alu_zx = 1'b0;
    alu_nx = 1'b0;
    alu_zy = 1'b0;
    alu_ny = 1'b0;
    alu_f  = 1'b0;
    alu_no = 1'b0;
    if (state_q == S_EXEC) begin
      {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[11:6];
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_hack_ctrl.sv
// tb_hack_ctrl: bench for hack_ctrl. It provides the instruction ROM, the
// data RAM and a Hack ALU. It checks a vector table of single-instruction
// cases, several hand-written multi-cycle sequences, and a random program
// run against an instruction-level model.
module tb_hack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req, instr_ack;
  logic [14:0] instr_addr;
  logic [15:0] instr_data;
  logic        mem_req, mem_we, mem_ack;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] pc;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  logic [15:0] m_mem [0:32767];
  logic [30:0] exp_q [$];
  logic [14:0] fetch_pcs [$];

  int instr_delay_cfg = 0;
  int mem_delay_cfg = 0;
  int fetch_cnt, rd_acks, rd_cycles, rd_addr_bad, ctrl_cycles, req_cyc, overlap_cnt;
  logic [14:0] rd_watch;
  logic [5:0]  last_ctrl;
  logic [14:0] snap_pc;
  logic [15:0] snap_x, snap_y;
  bit          model_on = 0;
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d;

  always #5 clk = ~clk;

  hack_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack), .instr_data(instr_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_x(alu_x), .alu_y(alu_y), .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
    .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
    .alu_ng(alu_ng), .pc(pc), .halted(halted)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0000 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    return c[0] ? ~o : o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
  assign alu_zr  = (alu_out == 16'h0000);
  assign alu_ng  = alu_out[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: one whole Hack instruction per call.
  task automatic model_step();
    logic [15:0] ir, y, o;
    logic [14:0] nxt;
    logic        jmp;
    ir = imem[m_pc];
    if (!ir[15]) begin
      m_a  = {1'b0, ir[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      y   = ir[12] ? m_mem[m_a[14:0]] : m_a;
      o   = hack_alu(m_d, y, ir[11:6]);
      jmp = (ir[2] && o[15]) || (ir[1] && o == 16'h0) || (ir[0] && o != 16'h0 && !o[15]);
      if (ir[3]) begin
        m_mem[m_a[14:0]] = o;
        exp_q.push_back({m_a[14:0], o});
      end
      nxt = jmp ? m_a[14:0] : m_pc + 15'd1;
      if (ir[5]) m_a = o;
      if (ir[4]) m_d = o;
      m_pc = nxt;
    end
  endtask

  // Instruction ROM responder.
  initial begin : instr_responder
    int cnt, tgt;
    bit busy;
    busy = 0; cnt = 0; tgt = 0;
    instr_ack = 0; instr_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !instr_req) begin
        instr_ack = 0;
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1; cnt = 0;
          tgt = (instr_delay_cfg < 0) ? int'($urandom_range(0, 3)) : instr_delay_cfg;
        end
        if (cnt >= tgt) begin
          instr_ack = 1;
          instr_data = imem[instr_addr];
        end else begin
          instr_ack = 0;
          cnt++;
        end
      end
    end
  end

  // Data RAM responder and write scoreboard.
  initial begin : mem_responder
    int cnt, tgt;
    bit busy;
    logic [30:0] e;
    busy = 0; cnt = 0; tgt = 0;
    mem_ack = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem_req) begin
        mem_ack = 0;
        busy = 0;
      end else begin
        if (!busy) begin
          busy = 1; cnt = 0;
          tgt = (mem_delay_cfg < 0) ? int'($urandom_range(0, 3)) : mem_delay_cfg;
        end
        if (cnt >= tgt) begin
          mem_ack = 1;
          if (mem_we) begin
            dmem[mem_addr] = mem_wdata;
            if (exp_q.size() == 0) begin
              errors++; checks++;
              $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", mem_addr, mem_wdata);
            end else begin
              e = exp_q.pop_front();
              chk("mem_write", {mem_addr, mem_wdata}, {1'b0, e});
            end
          end else begin
            mem_rdata = dmem[mem_addr];
            rd_acks++;
          end
        end else begin
          mem_ack = 0;
          cnt++;
        end
      end
    end
  end

  // Output monitor: fetch starts, ALU control activity, read stability.
  initial begin : monitor
    bit prev_ireq;
    logic [5:0] ctrl;
    prev_ireq = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (instr_req && mem_req) overlap_cnt++;
        if (instr_req || mem_req) req_cyc++;
        if (mem_req && !mem_we) begin
          rd_cycles++;
          if (mem_addr !== rd_watch) rd_addr_bad++;
        end
        ctrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        if (ctrl != 6'b0) begin
          ctrl_cycles++;
          last_ctrl = ctrl;
        end
        if (instr_req && !prev_ireq) begin
          fetch_cnt++;
          fetch_pcs.push_back(pc);
          snap_pc = pc; snap_x = alu_x; snap_y = alu_y;
          if (model_on) begin
            chk("model_pc", pc, m_pc);
            chk("model_d", alu_x, m_d);
            model_step();
          end
        end
      end
      prev_ireq = rst_n && instr_req;
    end
  end

  task automatic reset_assert(input bit clear_mem);
    rst_n = 0;
    model_on = 0;
    @(negedge clk);
    if (clear_mem) begin
      for (int i = 0; i < 32768; i++) begin
        imem[i] = 16'h0000;
        dmem[i] = 16'h0000;
      end
    end
    exp_q.delete();
  endtask

  task automatic reset_release();
    @(negedge clk);
    fetch_pcs.delete();
    fetch_cnt = 0; rd_acks = 0; rd_cycles = 0; rd_addr_bad = 0;
    ctrl_cycles = 0; last_ctrl = '0; req_cyc = 0;
    snap_pc = 'x; snap_x = 'x; snap_y = 'x;
    #2 rst_n = 1;
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (fetch_cnt < n && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("fetch_progress", fetch_cnt, n);
  endtask

  function automatic logic [14:0] pc_at(input int k);
    if (k < fetch_pcs.size()) return fetch_pcs[k];
    return 'x;
  endfunction

  typedef struct {
    logic [15:0] d_init;
    logic [15:0] a_val;
    logic [15:0] m_val;
    logic [15:0] instr;
    logic [14:0] exp_pc;
    logic [15:0] exp_d;
    logic        exp_wr;
    logic [15:0] exp_wdata;
    int          exp_reads;
  } vec_t;

  vec_t vecs [9];

  initial begin : main
    vecs[0] = '{16'h0000, 16'd100, 16'd7, 16'hFDC8, 15'd4,   16'h0000, 1'b1, 16'd8,    2}; // M=M+1
    vecs[1] = '{16'hFFFF, 16'd20,  16'd0, 16'hE304, 15'd20,  16'hFFFF, 1'b0, 16'd0,    1}; // D;JLT taken
    vecs[2] = '{16'h0000, 16'd20,  16'd0, 16'hE304, 15'd4,   16'h0000, 1'b0, 16'd0,    1}; // D;JLT not taken
    vecs[3] = '{16'h0003, 16'd4,   16'd0, 16'hE090, 15'd4,   16'h0007, 1'b0, 16'd0,    1}; // D=D+A
    vecs[4] = '{16'h0000, 16'd50,  16'd0, 16'hE302, 15'd50,  16'h0000, 1'b0, 16'd0,    1}; // D;JEQ taken
    vecs[5] = '{16'h0001, 16'd60,  16'd0, 16'hE301, 15'd60,  16'h0001, 1'b0, 16'd0,    1}; // D;JGT taken
    vecs[6] = '{16'h8000, 16'd60,  16'd0, 16'hE301, 15'd4,   16'h8000, 1'b0, 16'd0,    1}; // D;JGT negative
    vecs[7] = '{16'h0000, 16'd200, 16'd0, 16'hFC98, 15'd4,   16'hFFFF, 1'b1, 16'hFFFF, 2}; // MD=M-1
    vecs[8] = '{16'h0123, 16'd300, 16'd0, 16'hE327, 15'd300, 16'h0123, 1'b0, 16'd0,    1}; // A=D;JMP old A
    overlap_cnt = 0;
    rd_watch = '0;

    // Reset state.
    reset_assert(1);
    @(negedge clk); #1;
    chk("rst_instr_req", instr_req, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_d", alu_x, 0);
    chk("rst_a", alu_y, 0);

    // @5; D=A with zero-wait acks.
    imem[0] = 16'h0005; imem[1] = 16'hEC10;
    reset_release();
    wait_fetches(3, 100);
    chk("p27_first_pc", pc_at(0), 0);
    chk("p27_pc", snap_pc, 2);
    chk("p27_d", snap_x, 5);
    chk("p27_a", snap_y, 5);
    chk("p27_ctrl_cycles", ctrl_cycles, 1);
    chk("p27_ctrl", last_ctrl, 6'b110000);

    // Vector table: @0x7000; D=M; @a; <instr>, observed at the fifth fetch.
    foreach (vecs[i]) begin
      reset_assert(1);
      imem[0] = 16'h7000; imem[1] = 16'hFC10;
      imem[2] = vecs[i].a_val; imem[3] = vecs[i].instr;
      dmem[15'h7000] = vecs[i].d_init;
      dmem[vecs[i].a_val[14:0]] = vecs[i].m_val;
      if (vecs[i].exp_wr) exp_q.push_back({vecs[i].a_val[14:0], vecs[i].exp_wdata});
      instr_delay_cfg = (i % 2 == 1) ? -1 : 0;
      mem_delay_cfg = (i % 3 == 2) ? -1 : 0;
      reset_release();
      wait_fetches(5, 500);
      chk($sformatf("vec%0d_pc", i), snap_pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_d", i), snap_x, vecs[i].exp_d);
      chk($sformatf("vec%0d_pending_writes", i), exp_q.size(), 0);
      chk($sformatf("vec%0d_reads", i), rd_acks, vecs[i].exp_reads);
    end
    instr_delay_cfg = 0; mem_delay_cfg = 0;

    // Read ack held back 5 cycles: request and address held stable.
    reset_assert(1);
    imem[0] = 16'd100; imem[1] = 16'hFC10; dmem[100] = 16'h1234;
    rd_watch = 15'd100;
    mem_delay_cfg = 5;
    reset_release();
    wait_fetches(3, 200);
    chk("p30_read_cycles", rd_cycles, 6);   // 5 wait cycles plus the ack cycle
    chk("p30_addr_unstable", rd_addr_bad, 0);
    chk("p30_d", snap_x, 16'h1234);
    chk("p30_pc", snap_pc, 2);
    mem_delay_cfg = 0;
    rd_watch = '0;

    // Reset pulsed while a fetch is waiting for its ack.
    reset_assert(1);
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0009;
    instr_delay_cfg = 10;
    reset_release();
    wait_fetches(4, 200);
    @(negedge clk); #1;
    chk("p31_pending_req", instr_req, 1);
    rst_n = 0;
    #1;
    chk("p31_req_drop", instr_req, 0);
    chk("p31_pc_zero", pc, 0);
    chk("p31_d_zero", alu_x, 0);
    chk("p31_a_zero", alu_y, 0);
    instr_delay_cfg = 0;
    reset_release();
    wait_fetches(1, 50);
    chk("p31_refetch_pc", snap_pc, 0);
    chk("p31_refetch_d", snap_x, 0);
    chk("p31_refetch_a", snap_y, 0);

    // PC wrap from 0x7FFF to 0x0000.
    reset_assert(1);
    imem[0] = 16'h7FFF; imem[1] = 16'hEA87; imem[32767] = 16'h0000;
    reset_release();
    wait_fetches(4, 100);
    chk("wrap_pc1", pc_at(1), 1);
    chk("wrap_pc2", pc_at(2), 15'h7FFF);
    chk("wrap_pc3", pc_at(3), 0);

    // Idle loop @7; 0;JMP at address 7.
    reset_assert(1);
    imem[0] = 16'h0007; imem[1] = 16'hEA87; imem[7] = 16'h0007; imem[8] = 16'hEA87;
    reset_release();
`ifdef HACK_CTRL_HALT_DETECT_EN
    begin
      int cyc, before;
      cyc = 0;
      while (halted !== 1'b1 && cyc < 200) begin
        @(posedge clk);
        cyc++;
      end
      #1;
      chk("halt_flag", halted, 1);
      chk("halt_fetches", fetch_cnt, 4);
      before = req_cyc;
      repeat (30) @(posedge clk);
      #1;
      chk("halt_no_req", req_cyc - before, 0);
      chk("halt_stays", halted, 1);
    end
`else
    wait_fetches(8, 300);
    for (int k = 2; k < 8; k++) begin
      chk($sformatf("loop_pc%0d", k), pc_at(k), (k % 2 == 0) ? 7 : 8);
    end
    chk("loop_not_halted", halted, 0);
`endif

    // Random program against the instruction-level model.
    reset_assert(1);
    for (int i = 0; i < 32768; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15] && w[2:0] == 3'b111) w[2:0] = 3'b011;
      imem[i] = w;
      dmem[i] = 16'($urandom);
      m_mem[i] = dmem[i];
    end
    m_pc = '0; m_a = '0; m_d = '0;
    instr_delay_cfg = -1; mem_delay_cfg = -1;
    model_on = 1;
    reset_release();
    wait_fetches(400, 20000);
    model_on = 0;
    reset_assert(0);

    chk("req_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
